// File: rtl/puls_generator.sv
// Pulse-train generator: emits pulse_count high phases of high_time cycles separated by
// low_time cycles, with abort (stop), completion strobe (done) and a pulse counter.
module puls_generator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] high_time,
  input  logic [WIDTH-1:0] low_time,
  input  logic [WIDTH-1:0] pulse_count,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulses_sent
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] high_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] phase_q;
  logic [WIDTH-1:0] eff_high;
  logic [WIDTH-1:0] eff_low;
  logic [WIDTH-1:0] sent_inc;

  // A zero time is treated as a one-cycle phase.
  assign eff_high = (high_time == '0) ? One : high_time;
  assign eff_low  = (low_time == '0) ? One : low_time;
  assign sent_inc = pulses_sent + One;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      signal      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
      high_q      <= '0;
      low_q       <= '0;
      count_q     <= '0;
      phase_q     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            high_q      <= eff_high;
            low_q       <= eff_low;
            count_q     <= pulse_count;
            pulses_sent <= '0;
            if (pulse_count == '0) begin
              // Empty train: pass through DONE, strobe comes one cycle later.
              state_q <= StDone;
            end else begin
              state_q <= StHigh;
              signal  <= 1'b1;
              busy    <= 1'b1;
              phase_q <= eff_high - One;
            end
          end
        end
        StHigh: begin
          if (stop) begin
            state_q <= StIdle;
            signal  <= 1'b0;
            busy    <= 1'b0;
          end else if (phase_q == '0) begin
            pulses_sent <= sent_inc;
            signal      <= 1'b0;
            if (sent_inc == count_q) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StLow;
              phase_q <= low_q - One;
            end
          end else begin
            phase_q <= phase_q - One;
          end
        end
        StLow: begin
          if (stop) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (phase_q == '0) begin
            state_q <= StHigh;
            signal  <= 1'b1;
            phase_q <= high_q - One;
          end else begin
            phase_q <= phase_q - One;
          end
        end
        StDone: begin
          // done already high means the strobe has been shown; otherwise show it now.
          if (done || stop) begin
            state_q <= StIdle;
          end else begin
            done <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
